vehicle_detect_conditioner: RTL and testbench
=============================================

Name: vehicle_detect_conditioner

Overview:
Upstream stage of the traffic light controller. Conditions the raw cross-road (CR) inductive-loop sensor into the clean CR_vehicle_detect level the controller consumes.
- Synchronises the sensor input and debounces it with separate qualify and hold-over times.
- Detects a stuck-on loop and asserts detect fail-safe while it is stuck.
- Counts vehicle arrivals for maintenance readout.

One clock period equals 1 s of system time.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on loop_raw (minimum 2).
- ON_CYCLES, 3, consecutive present samples required to assert detect (minimum 1).
- OFF_CYCLES, 5, consecutive absent samples required to deassert detect (minimum 1).
- STUCK_CYCLES, 60, presence duration in PRESENT/RELEASING that declares a stuck loop.
- CNT_W, 7, width of internal qualify/hold/stuck counters; must hold STUCK_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- loop_raw  in  1  asynchronous raw loop sensor, 1 = metal present.
- fault_clr  in  1  one-cycle request to clear the stuck fault.
- CR_vehicle_detect  out  1  conditioned detect level to the traffic light controller.
- detect_rise  out  1  one-cycle pulse on each qualified arrival.
- fault  out  1  stuck-loop fault flag.
- vehicle_count  out  8  saturating arrival count.

Behaviour:
- Reset: when rst is 0 at a clk edge, the following clear: all synchroniser flops, the state (to IDLE), all counters, CR_vehicle_detect, detect_rise, fault and vehicle_count. Reset has priority over every other event, including mid-PRESENT and STUCK.
- All outputs are registered.
- s = last synchroniser stage output.
- States: IDLE, ARMING, PRESENT, RELEASING, STUCK.
- IDLE (detect=0):
  - s=1: go to ARMING, qcnt=1.
  - If ON_CYCLES=1, go directly to PRESENT instead.
- ARMING (detect=0):
  - s=0: go to IDLE, qcnt=0.
  - s=1 and qcnt==ON_CYCLES-1: go to PRESENT. At the same edge, detect=1, detect_rise=1, vehicle_count+=1 (saturates at 255), scnt=1.
  - Otherwise qcnt++.
- PRESENT (detect=1):
  - scnt increments every cycle in PRESENT and in RELEASING.
  - scnt==STUCK_CYCLES-1: go to STUCK, fault=1. This check has priority over the s=0 transition.
  - s=0: go to RELEASING, hcnt=1.
- RELEASING (detect=1):
  - s=1: go back to PRESENT, hcnt=0, scnt not cleared. This bridges gaps without counting a new vehicle.
  - s=0 and hcnt==OFF_CYCLES-1: go to IDLE, detect=0, scnt=0.
  - Otherwise hcnt++. The stuck check applies here too.
- STUCK (detect=1 fail-safe, fault=1):
  - Exit only on fault_clr=1 with s=0 in the same cycle: go to IDLE, detect=0, fault=0.
  - fault_clr while s=1 is ignored.
  - No arrivals are counted in STUCK.
- Latency:
  - Raw rise sampled at edge k: detect high after edge k+SYNC_STAGES+ON_CYCLES-1 (k+4 at defaults).
  - Raw fall sampled at edge k: detect low after edge k+SYNC_STAGES+OFF_CYCLES-1 (k+6 at defaults).
- detect_rise is high for exactly one cycle per counted arrival and never on STUCK entry or exit.
- vehicle_count never wraps.

Decomposition:
- Shared package holds:
  - the state enum: 3-bit, IDLE=0, ARMING=1, PRESENT=2, RELEASING=3, STUCK=4;
  - default timing constants ON/OFF/STUCK;
  - the count width (8).
- One sub-module: sync_ff. It is a parameterised SYNC_STAGES flop chain, reset to 0, reused for other async inputs.
- The FSM and counters live in the top module.

Test Plan:
- Reset: rst=0 for 5 cycles with loop_raw=1 → all outputs 0. Release rst with loop_raw held 1 → CR_vehicle_detect=1 and detect_rise pulse exactly 4 edges after first sample; vehicle_count=1.
- Glitch reject: loop_raw=1 for 2 cycles then 0 → CR_vehicle_detect never asserts, no detect_rise, vehicle_count=0.
- Gap bridging:
  - after detect, loop_raw=0 for 3 cycles then 1 → detect stays 1, vehicle_count unchanged;
  - then loop_raw=0 for 10 cycles → detect falls 6 edges after first low sample.
- Stuck loop:
  - loop_raw=1 for 80 cycles → fault=1 after 60 cycles of presence, detect stays 1;
  - fault_clr pulse with loop_raw=1 → ignored;
  - loop_raw=0 then fault_clr after sync delay → fault=0, detect=0, state IDLE.
- Counting/saturation: 3 separated 10-cycle vehicles → 3 detect_rise pulses, count=3. Continue to 260 vehicles → count=255, holds.
- Reset mid-PRESENT: rst=0 for one edge while detect=1 → all outputs 0 next cycle. After release with loop_raw still 1, re-qualification takes the full 4 edges.

Source files
------------

// File: rtl/vehicle_detect_conditioner_pkg.sv
// Shared types and default timing for the cross-road loop conditioner.
// One clock period is one second of system time.
package vehicle_detect_conditioner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMING    = 3'd1,
        ST_PRESENT   = 3'd2,
        ST_RELEASING = 3'd3,
        ST_STUCK     = 3'd4
    } state_t;

    localparam int DEF_ON_CYCLES    = 3;
    localparam int DEF_OFF_CYCLES   = 5;
    localparam int DEF_STUCK_CYCLES = 60;
    localparam int VCOUNT_W         = 8;

endpackage

// File: rtl/vehicle_detect_conditioner_sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input; clears to 0.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/vehicle_detect_conditioner.sv
// Conditions the raw cross-road loop into a debounced detect level, flags a
// stuck-on loop and keeps a saturating arrival count.
module vehicle_detect_conditioner
    import vehicle_detect_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int ON_CYCLES    = DEF_ON_CYCLES,
    parameter int OFF_CYCLES   = DEF_OFF_CYCLES,
    parameter int STUCK_CYCLES = DEF_STUCK_CYCLES,
    parameter int CNT_W        = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                loop_raw,
    input  logic                fault_clr,
    output logic                CR_vehicle_detect,
    output logic                detect_rise,
    output logic                fault,
    output logic [VCOUNT_W-1:0] vehicle_count
);

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    function automatic logic [VCOUNT_W-1:0] sat_inc(input logic [VCOUNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic                w_s;
    state_t              r_state, w_state_nx;
    logic [CNT_W-1:0]    r_qcnt, w_qcnt_nx;
    logic [CNT_W-1:0]    r_hcnt, w_hcnt_nx;
    logic [CNT_W-1:0]    r_scnt, w_scnt_nx;
    logic                r_detect, w_detect_nx;
    logic                r_rise, w_rise_nx;
    logic                r_fault, w_fault_nx;
    logic [VCOUNT_W-1:0] r_count, w_count_nx;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (loop_raw),
        .o_q (w_s)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_qcnt_nx   = r_qcnt;
        w_hcnt_nx   = r_hcnt;
        w_scnt_nx   = r_scnt;
        w_detect_nx = r_detect;
        w_rise_nx   = 1'b0;
        w_fault_nx  = r_fault;
        w_count_nx  = r_count;

        case (r_state)
            ST_IDLE: begin
                w_detect_nx = 1'b0;
                if (w_s) begin
                    if (ON_CYCLES == 1) begin
                        w_state_nx  = ST_PRESENT;
                        w_detect_nx = 1'b1;
                        w_rise_nx   = 1'b1;
                        w_count_nx  = sat_inc(r_count);
                        w_scnt_nx   = CNT_ONE;
                        w_qcnt_nx   = '0;
                    end else begin
                        w_state_nx = ST_ARMING;
                        w_qcnt_nx  = CNT_ONE;
                    end
                end
            end

            ST_ARMING: begin
                if (!w_s) begin
                    w_state_nx = ST_IDLE;
                    w_qcnt_nx  = '0;
                end else if (r_qcnt == ON_LAST) begin
                    w_state_nx  = ST_PRESENT;
                    w_detect_nx = 1'b1;
                    w_rise_nx   = 1'b1;
                    w_count_nx  = sat_inc(r_count);
                    w_scnt_nx   = CNT_ONE;
                    w_qcnt_nx   = '0;
                end else begin
                    w_qcnt_nx = r_qcnt + CNT_ONE;
                end
            end

            ST_PRESENT, ST_RELEASING: begin
                // Stuck detection outranks any release or re-arrival decision
                if (r_scnt == STUCK_LAST) begin
                    w_state_nx = ST_STUCK;
                    w_fault_nx = 1'b1;
                    w_hcnt_nx  = '0;
                end else begin
                    w_scnt_nx = r_scnt + CNT_ONE;
                    if (w_s) begin
                        w_state_nx = ST_PRESENT;
                        w_hcnt_nx  = '0;
                    end else if ((r_state == ST_RELEASING && r_hcnt == OFF_LAST) ||
                                 (r_state == ST_PRESENT && OFF_CYCLES == 1)) begin
                        w_state_nx  = ST_IDLE;
                        w_detect_nx = 1'b0;
                        w_scnt_nx   = '0;
                        w_hcnt_nx   = '0;
                    end else if (r_state == ST_PRESENT) begin
                        w_state_nx = ST_RELEASING;
                        w_hcnt_nx  = CNT_ONE;
                    end else begin
                        w_hcnt_nx = r_hcnt + CNT_ONE;
                    end
                end
            end

            ST_STUCK: begin
                // A clear is honoured only once the loop actually reads empty
                if (fault_clr && !w_s) begin
                    w_state_nx  = ST_IDLE;
                    w_detect_nx = 1'b0;
                    w_fault_nx  = 1'b0;
                    w_scnt_nx   = '0;
                end
            end

            default: begin
                w_state_nx  = ST_IDLE;
                w_qcnt_nx   = '0;
                w_hcnt_nx   = '0;
                w_scnt_nx   = '0;
                w_detect_nx = 1'b0;
                w_fault_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_qcnt   <= '0;
            r_hcnt   <= '0;
            r_scnt   <= '0;
            r_detect <= 1'b0;
            r_rise   <= 1'b0;
            r_fault  <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_qcnt   <= w_qcnt_nx;
            r_hcnt   <= w_hcnt_nx;
            r_scnt   <= w_scnt_nx;
            r_detect <= w_detect_nx;
            r_rise   <= w_rise_nx;
            r_fault  <= w_fault_nx;
            r_count  <= w_count_nx;
        end
    end

    assign CR_vehicle_detect = r_detect;
    assign detect_rise       = r_rise;
    assign fault             = r_fault;
    assign vehicle_count     = r_count;

endmodule

// File: tb/tb_vehicle_detect_conditioner.sv
// Scoreboard bench: a run-length reference model predicts every cycle's outputs,
// a negedge monitor compares them against the conditioner.
module tb_vehicle_detect_conditioner;

    localparam int SYNC  = 2;
    localparam int ON    = 3;
    localparam int OFF   = 5;
    localparam int STUCK = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic       loop_raw;
    logic       fault_clr;
    logic       CR_vehicle_detect;
    logic       detect_rise;
    logic       fault;
    logic [7:0] vehicle_count;

    always #5 clk = ~clk;

    vehicle_detect_conditioner #(
        .SYNC_STAGES  (SYNC),
        .ON_CYCLES    (ON),
        .OFF_CYCLES   (OFF),
        .STUCK_CYCLES (STUCK),
        .CNT_W        (7)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .loop_raw          (loop_raw),
        .fault_clr         (fault_clr),
        .CR_vehicle_detect (CR_vehicle_detect),
        .detect_rise       (detect_rise),
        .fault             (fault),
        .vehicle_count     (vehicle_count)
    );

    typedef struct packed {
        logic       det;
        logic       rise;
        logic       flt;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks     = 0;
    int failures   = 0;
    int fail_lines = 0;
    int rise_seen  = 0;

    // Reference model state: raw samples in flight, run lengths of the
    // synchronised level, time since arrival, and the visible outputs.
    bit hist[$];
    int run1, run0, age, m_cnt;
    int m_arrivals = 0;
    bit m_det, m_rise, m_fault;
    bit m_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (fail_lines < 40)
                $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
            fail_lines++;
        end
    endtask

    task model_step(input bit raw, input bit clr, input bit rstn);
        if (!rstn) begin
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
            run1 = 0; run0 = 0; age = 0; m_cnt = 0;
            m_det = 0; m_rise = 0; m_fault = 0;
        end else begin
            m_s = hist.pop_front();
            hist.push_back(raw);
            run1 = m_s ? run1 + 1 : 0;
            run0 = m_s ? 0 : run0 + 1;
            m_rise = 0;
            if (m_fault) begin
                if (clr && !m_s) begin
                    m_fault = 0; m_det = 0; age = 0;
                end
            end else if (m_det) begin
                if (age == STUCK - 1) begin
                    m_fault = 1;
                end else begin
                    age++;
                    if (run0 >= OFF) begin
                        m_det = 0; age = 0;
                    end
                end
            end else if (run1 >= ON) begin
                m_det = 1; m_rise = 1; age = 1;
                m_arrivals++;
                if (m_cnt < 255) m_cnt++;
            end
        end
    endtask

    task step(input bit raw, input bit clr, input bit rstn);
        loop_raw  = raw;
        fault_clr = clr;
        rst       = rstn;
        model_step(raw, clr, rstn);
        exp_q.push_back('{det: m_det, rise: m_rise, flt: m_fault, cnt: 8'(m_cnt)});
        @(posedge clk);
        #2;
    endtask

    task run(input bit raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("detect", 32'(CR_vehicle_detect), 32'(mon_e.det));
            check("detect_rise", 32'(detect_rise), 32'(mon_e.rise));
            check("fault", 32'(fault), 32'(mon_e.flt));
            check("vehicle_count", 32'(vehicle_count), 32'(mon_e.cnt));
        end
        if (detect_rise === 1'b1) rise_seen++;
    end

    int on_len, off_len;

    initial begin
        // Reset held with the loop occupied, then released with it still occupied
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        run(1'b1, 10);
        run(1'b0, 10);

        // Two-sample glitch must be rejected
        run(1'b1, 2);
        run(1'b0, 10);

        // Short gap is bridged, long gap releases
        run(1'b1, 10);
        run(1'b0, 3);
        run(1'b1, 5);
        run(1'b0, 10);

        // Stuck loop, ignored clear while occupied, honoured clear once empty
        for (int i = 0; i < 80; i++) step(1'b1, (i == 70), 1'b1);
        run(1'b0, 3);
        step(1'b0, 1'b1, 1'b1);
        run(1'b0, 8);

        // Reset while detect is high, then full re-qualification
        run(1'b1, 6);
        step(1'b1, 1'b0, 1'b0);
        run(1'b1, 8);
        run(1'b0, 10);

        // Random traffic with occasional clears and resets
        for (int v = 0; v < 60; v++) begin
            on_len  = $urandom_range(1, 12);
            off_len = $urandom_range(1, 12);
            for (int i = 0; i < on_len; i++)
                step(1'b1, ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) != 0));
            for (int i = 0; i < off_len; i++)
                step(1'b0, ($urandom_range(0, 15) == 0), 1'b1);
        end
        run(1'b0, 10);

        // Saturation of the arrival counter
        for (int v = 0; v < 260; v++) begin
            run(1'b1, 4);
            run(1'b0, 6);
        end

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        check("count_saturated", 32'(vehicle_count), 32'd255);
        check("rise_total", 32'(rise_seen), 32'(m_arrivals));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
